exe_up_branch_resolve: RTL and testbench
========================================

Name: exe_up_branch_resolve

Overview:
- Upper EXE-stage slot: one pipeline register fed by the issue stage, a small integer ALU, and a branch resolver.
- Resolver compares the fetch-time prediction with the real outcome and produces corrDest, corrTake, repairAction, checkPoint and branchRisk.
- Results feed the PREMEM branch-amend stage directly downstream, which performs the actual flush.
- Tracks MIPS delay slots so that a branch-amend flush never kills the delay slot of the flushing branch.

Parameters:
- CKPT_W, 8, width of the checkpoint bundle, passed through unchanged.
- REPAIR_W, 4, width of repairAction. Bit0 NEED_REPAIR, bit1 DIR_WRONG, bit2 TARGET_WRONG, bit3 IS_RETURN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- IS_valid_w_i  in  1  issue stage holds a valid instruction
- EXE_up_allowin_w_o  out  1  this stage accepts this cycle
- SBA_okToChange_w_i  in  1  downstream branch-amend stage can accept
- EXE_up_valid_w_o  out  1  downstream transfer valid
- SBA_flush_w_i  in  1  downstream branch misprediction flush
- CP0_excOccur_w_i  in  1  exception commit flush
- IS_aluOp_i  in  4  0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 NOR,6 SLT,7 SLTU,8 SLL,9 SRL,10 SRA,11 LUI; others give 0
- IS_brType_i  in  4  0 none,1 BEQ,2 BNE,3 BGEZ,4 BGTZ,5 BLEZ,6 BLTZ,7 BGEZAL,8 BLTZAL,9 J,10 JAL,11 JR,12 JALR
- IS_srcA_i, IS_srcB_i  in  32  operands
- IS_imm_i  in  32  sign-extended immediate or 26-bit J index, zero-extended
- IS_VAddr_i  in  32  instruction PC
- IS_writeNum_i  in  5  destination GPR, 0 = no writeback
- IS_predDest_i  in  32  predicted target
- IS_predTake_i  in  1  predicted direction
- IS_checkPoint_i  in  CKPT_W  checkpoint
- EXE_up_writeNum_o  out  5  registered destination
- EXE_up_VAddr_o  out  32  registered PC
- EXE_up_aluRes_o  out  32  ALU result, or PC+8 for link branches
- EXE_up_corrDest_o  out  32  correct next-fetch address
- EXE_up_corrTake_o  out  1  correct direction
- EXE_up_repairAction_o  out  REPAIR_W  repair bits
- EXE_up_checkPoint_o  out  CKPT_W  pass-through
- EXE_up_isBranch_o  out  1  brType != 0
- EXE_up_branchRisk_o  out  1  branch whose delay slot has not yet entered this stage

Behaviour:
- Reset (rst==0 at posedge) clears hasData, isDS_r, dsPending and every registered field to 0. As a result, all outputs are 0 and EXE_up_allowin_w_o is 1.
- Flow control:
  - allowin = !hasData || SBA_okToChange_w_i.
  - kill = CP0_excOccur_w_i || (SBA_flush_w_i && !isDS_r).
  - EXE_up_valid_w_o = hasData && SBA_okToChange_w_i && !kill.
- Load: when allowin && IS_valid_w_i && !CP0_excOccur_w_i && !SBA_flush_w_i:
  - register all inputs;
  - hasData <= 1;
  - isDS_r <= dsPending.
- When allowin holds without a load: hasData <= 0.
- Kill clears hasData the next cycle regardless of allowin.
- CP0 flush has priority over everything. It also clears dsPending.
- dsPending is set when a valid branch transfers downstream, and cleared when the next instruction transfers.
- SBA_flush_w_i:
  - clears dsPending only if the held instruction is not the delay slot;
  - if the held instruction is the delay slot (isDS_r=1), it survives and transfers normally.
- Latency: one cycle from load to results. Results are combinational from the registers.
- Branch evaluation:
  - Compares are signed 32-bit.
  - taken: BEQ A==B; BNE A!=B; BGEZ/BGEZAL A>=0; BGTZ A>0; BLEZ A<=0; BLTZ/BLTZAL A<0; J/JAL/JR/JALR always.
  - Branch target = PC+4+(imm<<2), mod 2^32.
  - J target = {(PC+4)[31:28], imm[25:0], 2'b00}.
  - JR target = srcA.
  - corrDest = taken ? target : PC+8.
  - corrTake = taken.
- aluRes = PC+8 for types 7,8,10,12; otherwise the ALU result.
- ALU rules:
  - shifts use srcA[4:0] as the amount and srcB as the data;
  - LUI = {imm[15:0], 16'b0};
  - ADD/SUB wrap, with no overflow trap.
- repairAction (all bits 0 for non-branches):
  - DIR_WRONG = taken != predTake.
  - TARGET_WRONG = taken && predTake && target != predDest.
  - NEED_REPAIR = DIR_WRONG | TARGET_WRONG.
  - IS_RETURN = JR with the source register being $31, flagged by IS_writeNum_i==0 and brType 11.
- branchRisk_o = isBranch && !IS_valid_w_i, i.e. the delay slot is not yet waiting upstream.
- Stall: SBA_okToChange_w_i=0 freezes all registers. A CP0 flush during a stall still clears the stage.

Test Plan:
- Reset mid-transfer, with rst=0 for 1 cycle while hasData=1 -> next cycle EXE_up_valid_w_o=0, allowin=1, all outputs 0.
- BEQ at PC 0x1000, A=B=5, imm=4, predTake=0 -> corrTake=1, corrDest=0x1014, repairAction=4'b0011.
- BNE at PC 0x2000, A=B, predTake=0 -> corrDest=0x2008, repairAction=0, valid one cycle after load.
- JAL at PC 0x00400010, imm=0x100 -> corrDest=0x00000400, aluRes=0x00400018; the following delay slot loaded with isDS_r=1 survives SBA_flush_w_i=1 and transfers.
- Non-DS instruction held while SBA_flush_w_i=1 -> valid_o=0; an IS_valid_w_i in the same cycle is not loaded.
- SBA_okToChange_w_i=0 for 3 cycles with SRA A=4, B=0x80000000 held -> outputs stable at aluRes 0xF8000000. CP0_excOccur_w_i pulse clears the stage.

Source files
------------

// File: rtl/exe_up_branch_resolve.sv
// exe_up_branch_resolve
//   Upper EXE-stage slot: one pipeline register fed by the issue stage, a
//   small integer ALU and a branch resolver. The resolver compares the
//   fetch-time prediction with the real outcome and hands corrDest,
//   corrTake, repairAction, checkPoint and branchRisk to the downstream
//   branch-amend stage, which performs the actual flush. Delay slots are
//   tracked so that an amend flush never kills the delay slot of the
//   branch that caused it.
//
// Ports
//   clk, rst                 clock, synchronous active-low reset
//   IS_valid_w_i             issue stage offers an instruction
//   EXE_up_allowin_w_o       this stage accepts this cycle
//   SBA_okToChange_w_i       downstream can accept
//   EXE_up_valid_w_o         downstream transfer valid
//   SBA_flush_w_i            downstream misprediction flush
//   CP0_excOccur_w_i         exception commit flush (highest priority)
//   IS_*_i                   instruction fields captured on load
//   EXE_up_*_o               registered fields and resolved results
//                            (all zero while the stage is empty)
module exe_up_branch_resolve #(
  parameter int CKPT_W   = 8,
  parameter int REPAIR_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                IS_valid_w_i,
  output logic                EXE_up_allowin_w_o,
  input  logic                SBA_okToChange_w_i,
  output logic                EXE_up_valid_w_o,
  input  logic                SBA_flush_w_i,
  input  logic                CP0_excOccur_w_i,
  input  logic [3:0]          IS_aluOp_i,
  input  logic [3:0]          IS_brType_i,
  input  logic [31:0]         IS_srcA_i,
  input  logic [31:0]         IS_srcB_i,
  input  logic [31:0]         IS_imm_i,
  input  logic [31:0]         IS_VAddr_i,
  input  logic [4:0]          IS_writeNum_i,
  input  logic [31:0]         IS_predDest_i,
  input  logic                IS_predTake_i,
  input  logic [CKPT_W-1:0]   IS_checkPoint_i,
  output logic [4:0]          EXE_up_writeNum_o,
  output logic [31:0]         EXE_up_VAddr_o,
  output logic [31:0]         EXE_up_aluRes_o,
  output logic [31:0]         EXE_up_corrDest_o,
  output logic                EXE_up_corrTake_o,
  output logic [REPAIR_W-1:0] EXE_up_repairAction_o,
  output logic [CKPT_W-1:0]   EXE_up_checkPoint_o,
  output logic                EXE_up_isBranch_o,
  output logic                EXE_up_branchRisk_o
);

  localparam logic [3:0] BR_NONE   = 4'd0;
  localparam logic [3:0] BR_BEQ    = 4'd1;
  localparam logic [3:0] BR_BNE    = 4'd2;
  localparam logic [3:0] BR_BGEZ   = 4'd3;
  localparam logic [3:0] BR_BGTZ   = 4'd4;
  localparam logic [3:0] BR_BLEZ   = 4'd5;
  localparam logic [3:0] BR_BLTZ   = 4'd6;
  localparam logic [3:0] BR_BGEZAL = 4'd7;
  localparam logic [3:0] BR_BLTZAL = 4'd8;
  localparam logic [3:0] BR_J      = 4'd9;
  localparam logic [3:0] BR_JAL    = 4'd10;
  localparam logic [3:0] BR_JR     = 4'd11;
  localparam logic [3:0] BR_JALR   = 4'd12;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_SLTU = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRL  = 4'd9;
  localparam logic [3:0] OP_SRA  = 4'd10;
  localparam logic [3:0] OP_LUI  = 4'd11;

  // Stage state
  logic                has_data_q, has_data_d;
  logic                is_ds_q, is_ds_d;
  logic                ds_pending_q, ds_pending_d;
  logic [3:0]          alu_op_q, alu_op_d;
  logic [3:0]          br_type_q, br_type_d;
  logic [31:0]         src_a_q, src_a_d;
  logic [31:0]         src_b_q, src_b_d;
  logic [31:0]         imm_q, imm_d;
  logic [31:0]         vaddr_q, vaddr_d;
  logic [4:0]          write_num_q, write_num_d;
  logic [31:0]         pred_dest_q, pred_dest_d;
  logic                pred_take_q, pred_take_d;
  logic [CKPT_W-1:0]   ckpt_q, ckpt_d;

  // Combinational helpers
  logic                allowin_s, kill_s, xfer_s, load_s, is_branch_s;
  logic [31:0]         pc4_s, pc8_s, br_tgt_s, j_tgt_s;
  logic                taken_s;
  logic [31:0]         target_s;
  logic [31:0]         alu_s;
  logic                dir_wrong_s, tgt_wrong_s;
  logic [REPAIR_W-1:0] repair_s;
  logic                is_link_s;

  assign allowin_s   = !has_data_q || SBA_okToChange_w_i;
  // The delay slot of the amending branch must survive its own flush.
  assign kill_s      = CP0_excOccur_w_i || (SBA_flush_w_i && !is_ds_q);
  assign xfer_s      = has_data_q && SBA_okToChange_w_i && !kill_s;
  assign load_s      = allowin_s && IS_valid_w_i && !CP0_excOccur_w_i && !SBA_flush_w_i;
  assign is_branch_s = (br_type_q != BR_NONE);

  assign pc4_s    = vaddr_q + 32'd4;
  assign pc8_s    = vaddr_q + 32'd8;
  assign br_tgt_s = pc4_s + (imm_q << 2'd2);
  assign j_tgt_s  = {pc4_s[31:28], imm_q[25:0], 2'b00};

  // Branch direction and target resolution
  always_comb begin
    taken_s  = 1'b0;
    target_s = br_tgt_s;
    case (br_type_q)
      BR_BEQ:               taken_s = (src_a_q == src_b_q);
      BR_BNE:               taken_s = (src_a_q != src_b_q);
      BR_BGEZ, BR_BGEZAL:   taken_s = !src_a_q[31];
      BR_BGTZ:              taken_s = !src_a_q[31] && (src_a_q != 32'd0);
      BR_BLEZ:              taken_s = src_a_q[31] || (src_a_q == 32'd0);
      BR_BLTZ, BR_BLTZAL:   taken_s = src_a_q[31];
      BR_J, BR_JAL: begin
        taken_s  = 1'b1;
        target_s = j_tgt_s;
      end
      BR_JR, BR_JALR: begin
        taken_s  = 1'b1;
        target_s = src_a_q;
      end
      default: begin
        taken_s  = 1'b0;
        target_s = br_tgt_s;
      end
    endcase
  end

  // Integer ALU; shifts take the amount from srcA and the data from srcB
  always_comb begin
    alu_s = 32'd0;
    case (alu_op_q)
      OP_ADD:  alu_s = src_a_q + src_b_q;
      OP_SUB:  alu_s = src_a_q - src_b_q;
      OP_AND:  alu_s = src_a_q & src_b_q;
      OP_OR:   alu_s = src_a_q | src_b_q;
      OP_XOR:  alu_s = src_a_q ^ src_b_q;
      OP_NOR:  alu_s = ~(src_a_q | src_b_q);
      OP_SLT:  alu_s = {31'd0, ($signed(src_a_q) < $signed(src_b_q))};
      OP_SLTU: alu_s = {31'd0, (src_a_q < src_b_q)};
      OP_SLL:  alu_s = src_b_q << src_a_q[4:0];
      OP_SRL:  alu_s = src_b_q >> src_a_q[4:0];
      OP_SRA:  alu_s = $unsigned($signed(src_b_q) >>> src_a_q[4:0]);
      OP_LUI:  alu_s = {imm_q[15:0], 16'd0};
      default: alu_s = 32'd0;
    endcase
  end

  assign is_link_s = (br_type_q == BR_BGEZAL) || (br_type_q == BR_BLTZAL) ||
                     (br_type_q == BR_JAL)    || (br_type_q == BR_JALR);

  // Repair bits against the fetch-time prediction
  always_comb begin
    repair_s    = {REPAIR_W{1'b0}};
    dir_wrong_s = 1'b0;
    tgt_wrong_s = 1'b0;
    if (is_branch_s) begin
      dir_wrong_s = taken_s ^ pred_take_q;
      tgt_wrong_s = taken_s && pred_take_q && (target_s != pred_dest_q);
      repair_s[0] = dir_wrong_s | tgt_wrong_s;
      repair_s[1] = dir_wrong_s;
      repair_s[2] = tgt_wrong_s;
      // A JR through $31 is recognised by a zero destination field.
      repair_s[3] = (br_type_q == BR_JR) && (write_num_q == 5'd0);
    end else begin
      repair_s = {REPAIR_W{1'b0}};
    end
  end

  // Next-state: CP0 flush wins, then load, then kill/drain, else hold
  always_comb begin
    has_data_d   = has_data_q;
    is_ds_d      = is_ds_q;
    ds_pending_d = ds_pending_q;
    alu_op_d     = alu_op_q;
    br_type_d    = br_type_q;
    src_a_d      = src_a_q;
    src_b_d      = src_b_q;
    imm_d        = imm_q;
    vaddr_d      = vaddr_q;
    write_num_d  = write_num_q;
    pred_dest_d  = pred_dest_q;
    pred_take_d  = pred_take_q;
    ckpt_d       = ckpt_q;

    if (CP0_excOccur_w_i) begin
      has_data_d = 1'b0;
    end else if (load_s) begin
      has_data_d  = 1'b1;
      // A branch leaving this very cycle makes the incoming one its delay slot.
      is_ds_d     = ds_pending_q || (xfer_s && is_branch_s);
      alu_op_d    = IS_aluOp_i;
      br_type_d   = IS_brType_i;
      src_a_d     = IS_srcA_i;
      src_b_d     = IS_srcB_i;
      imm_d       = IS_imm_i;
      vaddr_d     = IS_VAddr_i;
      write_num_d = IS_writeNum_i;
      pred_dest_d = IS_predDest_i;
      pred_take_d = IS_predTake_i;
      ckpt_d      = IS_checkPoint_i;
    end else if (kill_s || allowin_s) begin
      has_data_d = 1'b0;
    end else begin
      has_data_d = has_data_q;
    end

    if (CP0_excOccur_w_i) begin
      ds_pending_d = 1'b0;
    end else if (SBA_flush_w_i && !is_ds_q) begin
      ds_pending_d = 1'b0;
    end else if (xfer_s) begin
      ds_pending_d = is_branch_s;
    end else begin
      ds_pending_d = ds_pending_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      has_data_q   <= 1'b0;
      is_ds_q      <= 1'b0;
      ds_pending_q <= 1'b0;
      alu_op_q     <= 4'd0;
      br_type_q    <= 4'd0;
      src_a_q      <= 32'd0;
      src_b_q      <= 32'd0;
      imm_q        <= 32'd0;
      vaddr_q      <= 32'd0;
      write_num_q  <= 5'd0;
      pred_dest_q  <= 32'd0;
      pred_take_q  <= 1'b0;
      ckpt_q       <= {CKPT_W{1'b0}};
    end else begin
      has_data_q   <= has_data_d;
      is_ds_q      <= is_ds_d;
      ds_pending_q <= ds_pending_d;
      alu_op_q     <= alu_op_d;
      br_type_q    <= br_type_d;
      src_a_q      <= src_a_d;
      src_b_q      <= src_b_d;
      imm_q        <= imm_d;
      vaddr_q      <= vaddr_d;
      write_num_q  <= write_num_d;
      pred_dest_q  <= pred_dest_d;
      pred_take_q  <= pred_take_d;
      ckpt_q       <= ckpt_d;
    end
  end

  // Results are zeroed while the slot is empty so stale fields never leak.
  assign EXE_up_allowin_w_o    = allowin_s;
  assign EXE_up_valid_w_o      = xfer_s;
  assign EXE_up_writeNum_o     = has_data_q ? write_num_q : 5'd0;
  assign EXE_up_VAddr_o        = has_data_q ? vaddr_q : 32'd0;
  assign EXE_up_aluRes_o       = !has_data_q ? 32'd0 : (is_link_s ? pc8_s : alu_s);
  assign EXE_up_corrDest_o     = !has_data_q ? 32'd0 : (taken_s ? target_s : pc8_s);
  assign EXE_up_corrTake_o     = has_data_q && taken_s;
  assign EXE_up_repairAction_o = has_data_q ? repair_s : {REPAIR_W{1'b0}};
  assign EXE_up_checkPoint_o   = has_data_q ? ckpt_q : {CKPT_W{1'b0}};
  assign EXE_up_isBranch_o     = has_data_q && is_branch_s;
  assign EXE_up_branchRisk_o   = has_data_q && is_branch_s && !IS_valid_w_i;

endmodule

// File: tb/tb_exe_up_branch_resolve.sv
// Bench for exe_up_branch_resolve: directed scenarios followed by random
// traffic, every cycle compared against a behavioural model of the stage.
module tb_exe_up_branch_resolve;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  br;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  wn;
    logic [31:0] pd;
    logic        pt;
    logic [7:0]  ck;
  } ins_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_v, ok, flush, cp0;
  ins_t cur;

  logic        allowin, valid_o, take_o, isbr_o, risk_o;
  logic [4:0]  wn_o;
  logic [31:0] pc_o, alu_o, dest_o;
  logic [3:0]  rep_o;
  logic [7:0]  ck_o;

  exe_up_branch_resolve #(.CKPT_W(8), .REPAIR_W(4)) dut (
    .clk(clk), .rst(rst),
    .IS_valid_w_i(in_v), .EXE_up_allowin_w_o(allowin),
    .SBA_okToChange_w_i(ok), .EXE_up_valid_w_o(valid_o),
    .SBA_flush_w_i(flush), .CP0_excOccur_w_i(cp0),
    .IS_aluOp_i(cur.op), .IS_brType_i(cur.br),
    .IS_srcA_i(cur.a), .IS_srcB_i(cur.b), .IS_imm_i(cur.imm),
    .IS_VAddr_i(cur.pc), .IS_writeNum_i(cur.wn),
    .IS_predDest_i(cur.pd), .IS_predTake_i(cur.pt), .IS_checkPoint_i(cur.ck),
    .EXE_up_writeNum_o(wn_o), .EXE_up_VAddr_o(pc_o), .EXE_up_aluRes_o(alu_o),
    .EXE_up_corrDest_o(dest_o), .EXE_up_corrTake_o(take_o),
    .EXE_up_repairAction_o(rep_o), .EXE_up_checkPoint_o(ck_o),
    .EXE_up_isBranch_o(isbr_o), .EXE_up_branchRisk_o(risk_o)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // ---------------- behavioural model ----------------
  logic m_has, m_isds, m_pend;
  ins_t m_ins;

  function automatic logic [31:0] ref_alu(input ins_t x);
    int unsigned sh;
    logic [31:0] r;
    int sa, sb;
    sh = x.a & 32'd31;
    sa = x.a;
    sb = x.b;
    case (x.op)
      4'd0:  return x.a + x.b;
      4'd1:  return x.a - x.b;
      4'd2:  return x.a & x.b;
      4'd3:  return x.a | x.b;
      4'd4:  return x.a ^ x.b;
      4'd5:  return ~(x.a | x.b);
      4'd6:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd7:  return (x.a < x.b) ? 32'd1 : 32'd0;
      4'd8:  return x.b << sh;
      4'd9:  return x.b >> sh;
      4'd10: begin
        r = x.b >> sh;
        if (x.b[31]) r = r | ~(32'hFFFF_FFFF >> sh);
        return r;
      end
      4'd11: return (x.imm & 32'h0000_FFFF) * 32'd65536;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_taken(input ins_t x);
    int sa, sb;
    sa = x.a;
    sb = x.b;
    case (x.br)
      4'd1:        return sa == sb;
      4'd2:        return sa != sb;
      4'd3, 4'd7:  return sa >= 0;
      4'd4:        return sa > 0;
      4'd5:        return sa <= 0;
      4'd6, 4'd8:  return sa < 0;
      4'd9, 4'd10, 4'd11, 4'd12: return 1'b1;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_target(input ins_t x);
    if (x.br >= 4'd1 && x.br <= 4'd8) return x.pc + 32'd4 + x.imm * 32'd4;
    if (x.br == 4'd9 || x.br == 4'd10)
      return ((x.pc + 32'd4) & 32'hF000_0000) | ((x.imm & 32'h03FF_FFFF) * 32'd4);
    if (x.br == 4'd11 || x.br == 4'd12) return x.a;
    return 32'd0;
  endfunction

  task automatic check_all();
    logic tk, isb, dw, tw;
    logic [31:0] tg, e_alu, e_dest;
    logic [3:0] e_rep;
    logic kill;
    kill = cp0 || (flush && !m_isds);
    chk("allowin", allowin, !m_has || ok);
    chk("valid", valid_o, m_has && ok && !kill);
    if (m_has) begin
      tk  = ref_taken(m_ins);
      tg  = ref_target(m_ins);
      isb = (m_ins.br != 4'd0);
      e_dest = tk ? tg : m_ins.pc + 32'd8;
      e_alu  = (m_ins.br == 4'd7 || m_ins.br == 4'd8 || m_ins.br == 4'd10 || m_ins.br == 4'd12)
               ? m_ins.pc + 32'd8 : ref_alu(m_ins);
      dw = isb && (tk != m_ins.pt);
      tw = isb && tk && m_ins.pt && (tg != m_ins.pd);
      e_rep = {isb && m_ins.br == 4'd11 && m_ins.wn == 5'd0, tw, dw, dw | tw};
      chk("aluRes", alu_o, e_alu);
      chk("corrDest", dest_o, e_dest);
      chk("corrTake", take_o, tk);
      chk("repair", rep_o, e_rep);
      chk("isBranch", isbr_o, isb);
      chk("risk", risk_o, isb && !in_v);
      chk("writeNum", wn_o, m_ins.wn);
      chk("VAddr", pc_o, m_ins.pc);
      chk("ckpt", ck_o, m_ins.ck);
    end else begin
      chk("e_alu", alu_o, 32'd0);
      chk("e_dest", dest_o, 32'd0);
      chk("e_misc", {take_o, rep_o, isbr_o, risk_o, wn_o, ck_o}, 32'd0);
      chk("e_pc", pc_o, 32'd0);
    end
  endtask

  task automatic model_update();
    logic allow, kill, xfer, load, isb;
    if (!rst) begin
      m_has = 1'b0; m_isds = 1'b0; m_pend = 1'b0; m_ins = '0;
    end else begin
      isb   = m_ins.br != 4'd0;
      allow = !m_has || ok;
      kill  = cp0 || (flush && !m_isds);
      xfer  = m_has && ok && !kill;
      load  = allow && in_v && !cp0 && !flush;
      if (load) begin
        m_isds = m_pend || (xfer && isb);
        m_ins  = cur;
        m_has  = 1'b1;
      end else if (cp0 || kill || allow) begin
        m_has = 1'b0;
      end
      if (cp0) m_pend = 1'b0;
      else if (flush && !m_isds_prev(kill, cp0)) m_pend = 1'b0;
      else if (xfer) m_pend = isb;
    end
  endtask

  // kill without cp0 means the held instruction was not the delay slot
  function automatic logic m_isds_prev(input logic kill, input logic c);
    return !(kill && !c);
  endfunction

  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic set_ins(input logic [3:0] op, input logic [3:0] br, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic [31:0] pc,
                         input logic [4:0] wn, input logic [31:0] pd, input logic pt);
    cur.op = op; cur.br = br; cur.a = a; cur.b = b; cur.imm = imm; cur.pc = pc;
    cur.wn = wn; cur.pd = pd; cur.pt = pt; cur.ck = pc[9:2];
  endtask

  task automatic rand_ins();
    logic [31:0] x;
    int unsigned r;
    x = $urandom;
    r = $urandom_range(0, 3);
    cur.op  = 4'($urandom_range(0, 15));
    cur.br  = 4'($urandom_range(0, 12));
    cur.a   = (r == 0) ? 32'd0 : (r == 1) ? 32'($urandom_range(0, 3)) : $urandom;
    cur.b   = ($urandom_range(0, 2) == 0) ? cur.a : $urandom;
    cur.imm = ($urandom_range(0, 1) == 1) ? {{16{x[15]}}, x[15:0]} : {6'd0, x[25:0]};
    cur.pc  = $urandom & 32'hFFFF_FFFC;
    cur.wn  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
    cur.pt  = 1'($urandom_range(0, 1));
    cur.ck  = 8'($urandom);
    cur.pd  = ($urandom_range(0, 1) == 1) ? ref_target(cur) : $urandom;
  endtask

  initial begin
    rst = 1'b0; in_v = 1'b0; ok = 1'b1; flush = 1'b0; cp0 = 1'b0;
    cur = '0;
    m_has = 1'b0; m_isds = 1'b0; m_pend = 1'b0; m_ins = '0;
    @(negedge clk);
    @(posedge clk);
    model_update();
    @(negedge clk);

    // reset state
    cycle();
    rst = 1'b1;
    chk("rst_allowin", allowin, 32'd1);
    chk("rst_valid", valid_o, 32'd0);

    // reset while holding data
    set_ins(4'd0, 4'd0, 32'd1, 32'd2, 32'd0, 32'h100, 5'd3, 32'd0, 1'b0);
    in_v = 1'b1; cycle(); in_v = 1'b0;
    chk("mid_alu", alu_o, 32'd3);
    rst = 1'b0; cycle(); rst = 1'b1;
    chk("mid_allowin", allowin, 32'd1);
    chk("mid_valid", valid_o, 32'd0);
    chk("mid_pc", pc_o, 32'd0);

    // BEQ taken, predicted not taken
    set_ins(4'd0, 4'd1, 32'd5, 32'd5, 32'd4, 32'h1000, 5'd0, 32'd0, 1'b0);
    in_v = 1'b1; cycle(); in_v = 1'b0;
    chk("beq_take", take_o, 32'd1);
    chk("beq_dest", dest_o, 32'h0000_1014);
    chk("beq_rep", rep_o, 32'h3);
    set_ins(4'd0, 4'd0, 32'd0, 32'd0, 32'd0, 32'h1004, 5'd0, 32'd0, 1'b0);
    in_v = 1'b1; cycle(); in_v = 1'b0; cycle();

    // BNE not taken, correctly predicted
    set_ins(4'd0, 4'd2, 32'd7, 32'd7, 32'd16, 32'h2000, 5'd0, 32'd0, 1'b0);
    in_v = 1'b1; cycle(); in_v = 1'b0;
    chk("bne_dest", dest_o, 32'h0000_2008);
    chk("bne_rep", rep_o, 32'd0);
    chk("bne_valid", valid_o, 32'd1);
    set_ins(4'd0, 4'd0, 32'd0, 32'd0, 32'd0, 32'h2004, 5'd0, 32'd0, 1'b0);
    in_v = 1'b1; cycle(); in_v = 1'b0; cycle();

    // JAL then delay slot surviving the amend flush
    set_ins(4'd0, 4'd10, 32'd0, 32'd0, 32'h100, 32'h0040_0010, 5'd31, 32'h400, 1'b1);
    in_v = 1'b1; cycle();
    chk("jal_dest", dest_o, 32'h0000_0400);
    chk("jal_alu", alu_o, 32'h0040_0018);
    set_ins(4'd0, 4'd0, 32'd3, 32'd4, 32'd0, 32'h0040_0014, 5'd2, 32'd0, 1'b0);
    cycle(); in_v = 1'b0;
    flush = 1'b1; #1;
    chk("ds_flush_valid", valid_o, 32'd1);
    chk("ds_alu", alu_o, 32'd7);
    cycle(); flush = 1'b0;
    chk("ds_gone", allowin, 32'd1);

    // non-delay-slot instruction killed, same-cycle issue not loaded
    set_ins(4'd0, 4'd0, 32'd1, 32'd1, 32'd0, 32'h3000, 5'd4, 32'd0, 1'b0);
    in_v = 1'b1; cycle();
    set_ins(4'd4, 4'd0, 32'd6, 32'd3, 32'd0, 32'h3004, 5'd5, 32'd0, 1'b0);
    flush = 1'b1; #1;
    chk("nds_valid", valid_o, 32'd0);
    cycle(); flush = 1'b0; in_v = 1'b0;
    chk("nds_pc", pc_o, 32'd0);

    // stall holds SRA result, CP0 clears it
    set_ins(4'd10, 4'd0, 32'd4, 32'h8000_0000, 32'd0, 32'h4000, 5'd5, 32'd0, 1'b0);
    in_v = 1'b1; cycle();
    ok = 1'b0;
    set_ins(4'd0, 4'd0, 32'd9, 32'd9, 32'd0, 32'h5000, 5'd6, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_alu", alu_o, 32'hF800_0000);
      chk("stall_allowin", allowin, 32'd0);
    end
    cp0 = 1'b1; cycle(); cp0 = 1'b0; in_v = 1'b0; ok = 1'b1;
    chk("cp0_allowin", allowin, 32'd1);
    chk("cp0_alu", alu_o, 32'd0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      rand_ins();
      rst   = ($urandom_range(0, 63) != 0);
      in_v  = ($urandom_range(0, 9) < 7);
      ok    = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 9) == 0);
      cp0   = ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
